mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 212 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Sequences byte-wide data memory accesses for load/store requests of
//   byte, halfword or word size. Values are stored big-endian: the lowest
//   address holds the most significant byte. Loads are sign- or
//   zero-extended; out-of-range or illegal-size requests complete at once
//   with an error and never touch memory.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : request handshake (ready only in IDLE)
//   req_write         : 1 = store, 0 = load
//   req_size          : 00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned      : zero-extend loads (ignored for word loads)
//   req_addr/wdata    : start byte address, right-justified store data
//   resp_valid        : one-cycle completion pulse
//   resp_rdata        : extended load data, held until next response
//   resp_err          : error flag, qualified by resp_valid
//   mem_addr/wdata/we : byte-wide memory write/address port
//   mem_rdata         : combinational read byte for mem_addr
module mem_access_unit #(
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_BUS_WIDTH = 32,
  parameter int MEM_DEPTH      = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [ADDR_BUS_WIDTH-1:0] req_addr,
  input  logic [DATA_BUS_WIDTH-1:0] req_wdata,
  output logic                      resp_valid,
  output logic [DATA_BUS_WIDTH-1:0] resp_rdata,
  output logic                      resp_err,
  output logic [ADDR_BUS_WIDTH-1:0] mem_addr,
  output logic [7:0]                mem_wdata,
  output logic                      mem_we,
  input  logic [7:0]                mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int SHW = $clog2(DATA_BUS_WIDTH) + 1;
  localparam logic [SHW-1:0] SH_BYTE = SHW'(DATA_BUS_WIDTH - 8);
  localparam logic [SHW-1:0] SH_HALF = SHW'(DATA_BUS_WIDTH - 16);
  localparam logic [SHW-1:0] SH_WORD = SHW'(DATA_BUS_WIDTH - 32);

  state_t state, next_state;

  // Latched request. The size is kept as the index of the last byte (N-1).
  logic                      lat_write;
  logic                      lat_unsigned;
  logic [1:0]                last_k;
  logic [ADDR_BUS_WIDTH-1:0] lat_addr;
  logic [DATA_BUS_WIDTH-1:0] lat_wdata;

  logic [1:0]                k;
  logic [23:0]               acc;
  logic [DATA_BUS_WIDTH-1:0] rdata_q;
  logic                      err_q;

  // Request decode: N-1 for the incoming size and range check.
  logic [1:0]                req_last;
  logic [ADDR_BUS_WIDTH:0]   req_end;
  logic                      req_err;

  always_comb begin
    req_last = 2'd0;
    case (req_size)
      2'b01:   req_last = 2'd1;
      2'b10:   req_last = 2'd3;
      default: req_last = 2'd0;
    endcase
  end

  // One extra bit so a request near the top of the address space cannot
  // wrap around and look legal.
  assign req_end = {1'b0, req_addr} + (ADDR_BUS_WIDTH+1)'(req_last);
  assign req_err = (req_size == 2'b11) ||
                   (req_end >= (ADDR_BUS_WIDTH+1)'(MEM_DEPTH));

  // Big-endian: access k carries byte (N-1-k) of the value.
  logic [1:0] byte_idx;
  logic [7:0] store_byte;

  assign byte_idx = last_k - k;

  always_comb begin
    store_byte = 8'h00;
    case (byte_idx)
      2'd0: store_byte = lat_wdata[7:0];
      2'd1: store_byte = lat_wdata[15:8];
      2'd2: store_byte = lat_wdata[23:16];
      2'd3: store_byte = lat_wdata[31:24];
      default: store_byte = 8'h00;
    endcase
  end

  // Load extension: left-align the N-byte value, then shift back down
  // logically (zero-extend) or arithmetically (sign-extend).
  logic [31:0]                      load_raw;
  logic [SHW-1:0]                   ext_shift;
  logic [DATA_BUS_WIDTH-1:0]        aligned;
  logic signed [DATA_BUS_WIDTH-1:0] aligned_s;
  logic [DATA_BUS_WIDTH-1:0]        load_ext;

  assign load_raw = {acc, mem_rdata};

  always_comb begin
    ext_shift = SH_WORD;
    case (last_k)
      2'd0:    ext_shift = SH_BYTE;
      2'd1:    ext_shift = SH_HALF;
      default: ext_shift = SH_WORD;
    endcase
  end

  assign aligned   = DATA_BUS_WIDTH'(load_raw) << ext_shift;
  assign aligned_s = aligned;
  assign load_ext  = (lat_unsigned && (last_k != 2'd3)) ?
                     (aligned >> ext_shift) :
                     $unsigned(aligned_s >>> ext_shift);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and memory/handshake outputs.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 8'h00;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = ~rst;
        if (req_valid && !rst) next_state = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_addr = lat_addr + ADDR_BUS_WIDTH'(k);
        if (lat_write) begin
          mem_we    = 1'b1;
          mem_wdata = store_byte;
        end
        if (k == last_k) next_state = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: request latch, byte counter, accumulator, response registers.
  // The response data is captured on the edge entering RESP using the final
  // byte straight from mem_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_write    <= 1'b0;
      lat_unsigned <= 1'b0;
      last_k       <= 2'd0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      k            <= 2'd0;
      acc          <= 24'h0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write    <= req_write;
            lat_unsigned <= req_unsigned;
            last_k       <= req_last;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            k            <= 2'd0;
            acc          <= 24'h0;
            if (req_err) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          k <= k + 2'd1;
          if (!lat_write) acc <= load_raw[23:0];
          if (k == last_k) begin
            rdata_q <= lat_write ? '0 : load_ext;
            err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a 64-byte memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:63];

  int tests_run    = 0;
  int tests_failed = 0;

  // Results of the last do_req call.
  int          lat;
  int          we_cnt;
  int          act_cnt;
  int          addr_cnt;
  logic [31:0] addr_log [0:7];
  logic [31:0] got_rdata;
  logic        got_err;
  logic        after_valid;

  mem_access_unit #(
    .ADDR_BUS_WIDTH(32),
    .DATA_BUS_WIDTH(32),
    .MEM_DEPTH(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 8'h00;

  always @(posedge clk) begin
    if (mem_we && mem_addr < 32'd64) mem[mem_addr[5:0]] <= mem_wdata;
  end

  // Issue one request from IDLE and follow it to its response; records
  // latency (edges from acceptance, inclusive), memory activity and result.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = wd;
    lat = 0; we_cnt = 0; act_cnt = 0; addr_cnt = 0;
    got_rdata = 32'hDEAD_DEAD; got_err = 1'bx;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat++;
      if (resp_valid) begin
        got_rdata = resp_rdata;
        got_err   = resp_err;
        if (mem_we || mem_addr != 32'd0) act_cnt++;
        break;
      end
      if (mem_we) we_cnt++;
      if (mem_we || mem_addr != 32'd0) act_cnt++;
      if (addr_cnt < 8) addr_log[addr_cnt] = mem_addr;
      addr_cnt++;
    end
    if (!resp_valid) lat = -1;
    @(posedge clk); #1;
    after_valid = resp_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd8; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (req_ready !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 0", req_ready);
    end
    tests_run++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_resp: got valid=%b err=%b expected 0 0", resp_valid, resp_err);
    end
    tests_run++;
    if (resp_rdata !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL reset_rdata: got %h expected 00000000", resp_rdata);
    end
    tests_run++;
    if (mem_we !== 1'b0 || mem_addr !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL reset_mem: got we=%b addr=%h expected 0 0", mem_we, mem_addr);
    end
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL reset_release_ready: got %b expected 1", req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_byte();
    for (int i = 8; i < 12; i++) mem[i] = 8'hAA;
    do_req(1'b0, 2'b00, 1'b0, 32'd8, 32'h0);
    tests_run++;
    if (got_rdata !== 32'hFFFF_FFAA || got_err !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL lb_signed: got %h err=%b expected ffffffaa err=0", got_rdata, got_err);
    end
    tests_run++;
    if (lat != 2) begin
      tests_failed++; $display("[TB] FAIL lb_latency: got %0d expected 2", lat);
    end
    tests_run++;
    if (after_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL lb_pulse: got valid=%b after resp expected 0", after_valid);
    end
    do_req(1'b0, 2'b00, 1'b1, 32'd8, 32'h0);
    tests_run++;
    if (got_rdata !== 32'h0000_00AA) begin
      tests_failed++; $display("[TB] FAIL lbu: got %h expected 000000aa", got_rdata);
    end
    mem[63] = 8'h7F;
    do_req(1'b0, 2'b00, 1'b0, 32'd63, 32'h0);
    tests_run++;
    if (got_rdata !== 32'h0000_007F || got_err !== 1'b0 || lat != 2) begin
      tests_failed++; $display("[TB] FAIL lb_top_byte: got %h err=%b lat=%0d expected 0000007f 0 2", got_rdata, got_err, lat);
    end
  endtask

  task automatic test_load_word();
    for (int i = 4; i < 8; i++) mem[i] = 8'h33;
    do_req(1'b0, 2'b10, 1'b0, 32'd4, 32'h0);
    tests_run++;
    if (addr_cnt != 4 || addr_log[0] !== 32'd4 || addr_log[1] !== 32'd5 ||
        addr_log[2] !== 32'd6 || addr_log[3] !== 32'd7) begin
      tests_failed++; $display("[TB] FAIL lw_addr_seq: got n=%0d %0d %0d %0d %0d expected 4 4 5 6 7",
                               addr_cnt, addr_log[0], addr_log[1], addr_log[2], addr_log[3]);
    end
    tests_run++;
    if (got_rdata !== 32'h3333_3333 || lat != 5) begin
      tests_failed++; $display("[TB] FAIL lw_data: got %h lat=%0d expected 33333333 5", got_rdata, lat);
    end
    mem[16] = 8'h12; mem[17] = 8'h34; mem[18] = 8'h56; mem[19] = 8'h78;
    do_req(1'b0, 2'b10, 1'b1, 32'd16, 32'h0);
    tests_run++;
    if (got_rdata !== 32'h1234_5678) begin
      tests_failed++; $display("[TB] FAIL lw_endian: got %h expected 12345678", got_rdata);
    end
    mem[12] = 8'h80; mem[13] = 8'h01;
    do_req(1'b0, 2'b01, 1'b0, 32'd12, 32'h0);
    tests_run++;
    if (got_rdata !== 32'hFFFF_8001 || lat != 3) begin
      tests_failed++; $display("[TB] FAIL lh_signed: got %h lat=%0d expected ffff8001 3", got_rdata, lat);
    end
    do_req(1'b0, 2'b01, 1'b1, 32'd12, 32'h0);
    tests_run++;
    if (got_rdata !== 32'h0000_8001) begin
      tests_failed++; $display("[TB] FAIL lhu: got %h expected 00008001", got_rdata);
    end
    mem[60] = 8'h9A; mem[61] = 8'hBC; mem[62] = 8'hDE; mem[63] = 8'hF0;
    do_req(1'b0, 2'b10, 1'b0, 32'd60, 32'h0);
    tests_run++;
    if (got_rdata !== 32'h9ABC_DEF0 || got_err !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL lw_top_word: got %h err=%b expected 9abcdef0 0", got_rdata, got_err);
    end
  endtask

  task automatic test_store_half();
    mem[20] = 8'h00; mem[21] = 8'h00; mem[22] = 8'h00;
    do_req(1'b1, 2'b01, 1'b0, 32'd20, 32'h1234_BEEF);
    tests_run++;
    if (we_cnt != 2) begin
      tests_failed++; $display("[TB] FAIL sh_we_cycles: got %0d expected 2", we_cnt);
    end
    tests_run++;
    if (mem[20] !== 8'hBE || mem[21] !== 8'hEF || mem[22] !== 8'h00) begin
      tests_failed++; $display("[TB] FAIL sh_mem: got %h %h %h expected be ef 00", mem[20], mem[21], mem[22]);
    end
    tests_run++;
    if (got_rdata !== 32'h0 || got_err !== 1'b0 || lat != 3) begin
      tests_failed++; $display("[TB] FAIL sh_resp: got %h err=%b lat=%0d expected 00000000 0 3", got_rdata, got_err, lat);
    end
  endtask

  task automatic test_errors();
    // Leave a nonzero load result behind so the error response must clear it.
    do_req(1'b0, 2'b10, 1'b0, 32'd4, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'd62, 32'h0);
    tests_run++;
    if (got_err !== 1'b1 || lat != 1 || got_rdata !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL err_lw62: got err=%b lat=%0d rdata=%h expected 1 1 00000000", got_err, lat, got_rdata);
    end
    tests_run++;
    if (act_cnt != 0 || we_cnt != 0) begin
      tests_failed++; $display("[TB] FAIL err_lw62_activity: got act=%0d we=%0d expected 0 0", act_cnt, we_cnt);
    end
    do_req(1'b1, 2'b11, 1'b0, 32'd0, 32'hFFFF_FFFF);
    tests_run++;
    if (got_err !== 1'b1 || lat != 1 || act_cnt != 0) begin
      tests_failed++; $display("[TB] FAIL err_size11: got err=%b lat=%0d act=%0d expected 1 1 0", got_err, lat, act_cnt);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'd61, 32'h0);
    tests_run++;
    if (got_err !== 1'b1 || lat != 1) begin
      tests_failed++; $display("[TB] FAIL err_lw61: got err=%b lat=%0d expected 1 1", got_err, lat);
    end
    do_req(1'b1, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0000_5555);
    tests_run++;
    if (got_err !== 1'b1 || lat != 1 || act_cnt != 0) begin
      tests_failed++; $display("[TB] FAIL err_wrap: got err=%b lat=%0d act=%0d expected 1 1 0", got_err, lat, act_cnt);
    end
    do_req(1'b0, 2'b00, 1'b0, 32'd64, 32'h0);
    tests_run++;
    if (got_err !== 1'b1 || lat != 1) begin
      tests_failed++; $display("[TB] FAIL err_lb64: got err=%b lat=%0d expected 1 1", got_err, lat);
    end
  endtask

  task automatic test_reset_mid_store();
    int resp_seen;
    for (int i = 0; i < 4; i++) mem[i] = 8'h11;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (mem_we !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL rst_store_we: got %b expected 0", mem_we);
    end
    resp_seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (resp_valid) resp_seen++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (resp_seen != 0) begin
      tests_failed++; $display("[TB] FAIL rst_store_noresp: got %0d responses expected 0", resp_seen);
    end
    tests_run++;
    if (mem[0] !== 8'hCA || mem[1] !== 8'hFE || mem[2] !== 8'h11 || mem[3] !== 8'h11) begin
      tests_failed++; $display("[TB] FAIL rst_store_mem: got %h %h %h %h expected ca fe 11 11", mem[0], mem[1], mem[2], mem[3]);
    end
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL rst_store_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_back_to_back();
    int resp_n;
    int first_at;
    int second_at;
    logic ready_c3;
    logic [31:0] second_data;
    resp_n = 0; first_at = 0; second_at = 0; ready_c3 = 1'bx; second_data = 32'h0;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd8; req_wdata = 32'h0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      if (c == 3) ready_c3 = req_ready;
      if (resp_valid) begin
        resp_n++;
        if (resp_n == 1) first_at = c;
        if (resp_n == 2) begin second_at = c; second_data = resp_rdata; end
      end
      if (c == 5) req_valid = 1'b0;
    end
    tests_run++;
    if (resp_n != 2 || first_at != 2 || second_at != 5) begin
      tests_failed++; $display("[TB] FAIL b2b_timing: got n=%0d at %0d,%0d expected 2 at 2,5", resp_n, first_at, second_at);
    end
    tests_run++;
    if (ready_c3 !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL b2b_idle_gap: got ready=%b expected 1", ready_c3);
    end
    tests_run++;
    if (second_data !== 32'hFFFF_FFAA) begin
      tests_failed++; $display("[TB] FAIL b2b_data: got %h expected ffffffaa", second_data);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    test_reset();
    test_load_byte();
    test_load_word();
    test_store_half();
    test_errors();
    test_reset_mid_store();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
